// File: rtl/gb_pkg.sv
// Shared console definitions.
// DMA state encoding and memory-map constants.
package gb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_DMA_LEN = 160;
  localparam logic [7:0]  ECHO_PAGE   = 8'hE0;

  // Echo RAM pages fold back onto WRAM.
  function automatic logic [7:0] eff_page(input logic [7:0] p);
    return (p >= ECHO_PAGE) ? p - 8'h20 : p;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator (FF46).
// Copies LEN bytes from page XX00 into OAM, one per M-cycle.
module oam_dma
  import gb_pkg::*;
#(
  parameter int LEN         = OAM_DMA_LEN,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        reg_write,
  input  logic [7:0]  wdata,
  output logic [7:0]  reg_rdata,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write,
  output logic        dma_active
);

  localparam int DW =
    (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [DW-1:0] DLY  = DW'(START_DELAY);
  localparam logic [7:0]    LAST = 8'(LEN - 1);

  dma_state_t    state_q;
  logic [7:0]    page_q;
  logic [7:0]    xfer_page_q;
  logic [7:0]    idx_q;
  logic [DW-1:0] dly_q;
  logic          ovl_q;

  logic busy;
  logic last;

  // A restart keeps the old copy alive through START.
  assign busy = (state_q == XFER) ||
                ((state_q == START) && ovl_q);
  assign last = (idx_q == LAST);

  // Transfer sequencer: page latch, delay, index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      page_q      <= 8'h00;
      xfer_page_q <= 8'h00;
      idx_q       <= 8'd0;
      dly_q       <= '0;
      ovl_q       <= 1'b0;
    end else if (cpu_en) begin
      if (busy) begin
        idx_q <= last ? 8'd0 : idx_q + 8'd1;
      end
      if (reg_write) begin
        page_q  <= wdata;
        dly_q   <= DLY;
        state_q <= START;
        ovl_q   <= busy && !last;
      end else begin
        unique case (state_q)
          IDLE: ;
          START: begin
            dly_q <= dly_q - 1'b1;
            if (busy && last) begin
              ovl_q <= 1'b0;
            end
            if (dly_q <= DW'(1)) begin
              idx_q       <= 8'd0;
              xfer_page_q <= page_q;
              ovl_q       <= 1'b0;
              state_q     <= XFER;
            end
          end
          XFER: begin
            if (last) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign reg_rdata  = page_q;
  assign dma_active = busy;
  assign oam_write  = busy & cpu_en;
  assign oam_addr   = busy ? idx_q : 8'd0;
  assign src_addr   = busy ? {eff_page(xfer_page_q), idx_q}
                           : 16'h0000;
  assign oam_wdata  = src_rdata;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma.
// Stimulus pushes expected writes; a monitor pops them.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_en = 1'b1;
  logic        reg_write = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  reg_rdata;
  logic [15:0] src_addr;
  logic [7:0]  src_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic        dma_active;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .reg_write  (reg_write),
    .wdata      (wdata),
    .reg_rdata  (reg_rdata),
    .src_addr   (src_addr),
    .src_rdata  (src_rdata),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_write  (oam_write),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
  endfunction

  assign src_rdata = mem(src_addr);

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] src;
    int          en;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  int   act_cnt = 0;
  int   wr_cnt = 0;
  int   cyc = 0;
  bit   sparse = 1'b0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    cpu_en = sparse ? (cyc % 4 == 0) : 1'b1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (oam_write) begin
        wr_cnt++;
        chk("write_needs_en", cpu_en, 1);
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got idx %0d none expected",
                   oam_addr);
        end else begin
          e = q.pop_front();
          chk("oam_addr", oam_addr, e.idx);
          chk("src_addr", src_addr, e.src);
          chk("oam_wdata", oam_wdata, mem(e.src));
          if (e.en >= 0)
            chk("write_slot", en_cnt, e.en);
        end
      end
      if (cpu_en) begin
        if (dma_active) act_cnt++;
        en_cnt++;
      end
    end
  end

  task automatic push_run(input logic [7:0] ep,
                          input int from, input int to,
                          input int en0);
    exp_t e;
    for (int i = from; i <= to; i++) begin
      e.idx = 8'(i);
      e.src = {ep, 8'(i)};
      e.en  = en0 + (i - from);
      q.push_back(e);
    end
  endtask

  task automatic do_write(input logic [7:0] p, output int e);
    @(posedge clk);
    #2;
    while (!cpu_en) begin
      @(posedge clk);
      #2;
    end
    reg_write = 1'b1;
    wdata     = p;
    e         = en_cnt;
    @(posedge clk);
    #2;
    reg_write = 1'b0;
  endtask

  task automatic wait_write(input logic [7:0] a);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(oam_write && oam_addr == a) && k < 3000);
    if (k >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idx: got timeout expected idx %0d", a);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((q.size() != 0 || dma_active) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", q.size(), 0);
    chk("idle_inactive", dma_active, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int e;
    int e2;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rdata", reg_rdata, 8'h00);
    chk("rst_active", dma_active, 0);
    chk("rst_write", oam_write, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_src_addr", src_addr, 16'h0000);
    reset = 1'b0;

    act_cnt = 0;
    wr_cnt  = 0;
    do_write(8'hC1, e);
    push_run(8'hC1, 0, 159, e + 2);
    wait_done();
    chk("basic_writes", wr_cnt, 160);
    chk("basic_active", act_cnt, 160);
    chk("basic_rdata", reg_rdata, 8'hC1);

    do_write(8'hF2, e);
    push_run(8'hD2, 0, 159, e + 2);
    wait_done();

    sparse  = 1'b1;
    act_cnt = 0;
    wr_cnt  = 0;
    do_write(8'hA5, e);
    push_run(8'hA5, 0, 159, e + 2);
    wait_done();
    chk("sparse_writes", wr_cnt, 160);
    chk("sparse_active", act_cnt, 160);
    sparse = 1'b0;
    repeat (2) @(posedge clk);

    act_cnt = 0;
    do_write(8'h80, e);
    push_run(8'h80, 0, 50, e + 2);
    wait_write(8'd48);
    do_write(8'h90, e2);
    push_run(8'h90, 0, 159, e2 + 2);
    chk("restart_rdata", reg_rdata, 8'h90);
    wait_done();
    chk("restart_active", act_cnt, 211);

    do_write(8'h33, e);
    push_run(8'h33, 0, 100, e + 2);
    wait_write(8'd99);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("rstmid_write", oam_write, 0);
    chk("rstmid_active", dma_active, 0);
    chk("rstmid_rdata", reg_rdata, 8'h00);
    chk("rstmid_queue", q.size(), 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    do_write(8'h40, e);
    push_run(8'h40, 0, 159, e + 2);
    wait_write(8'd158);
    do_write(8'h41, e2);
    chk("final_fresh_active", dma_active, 0);
    chk("final_fresh_write", oam_write, 0);
    push_run(8'h41, 0, 159, e2 + 2);
    wait_done();
    chk("final_rdata", reg_rdata, 8'h41);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
